// File: rtl/alu_secuencial.sv
// -----------------------------------------------------------------------------
// alu_secuencial
//
// Multicycle ALU with a start/done handshake and registered outputs.
// It supports add, subtract, multiply, divide, modulo, AND, OR, XOR and
// logical shifts left and right. The flags are N, Z, C and V.
// Multiply, divide and modulo are computed iteratively, one bit per cycle,
// so the block needs no wide combinational multiplier or divider.
//
// Ports
//   clk        : rising-edge clock
//   reset      : synchronous, active-high reset
//   inicio     : request strobe, accepted only while ocupado = 0
//   operandoA  : operand A (W bits; unsigned for mul/div/mod)
//   operandoB  : operand B (W bits; also the shift amount)
//   seleccion  : opcode
//                0 add, 1 sub, 2 mul, 3 div, 4 mod,
//                5 AND, 6 OR, 7 XOR, 8 shl, 9 shr
//                10-15 return 0
//   ocupado    : high while an accepted operation is in flight
//   listo      : one-cycle pulse; resultado and the flags are valid from here
//   resultado  : registered result, held until the next listo
//   N, Z, C, V : registered flags, updated together with resultado
//   divCero    : (only with ALU_DIV_CERO_EN) division-by-zero indicator
//
// Build option
//   ALU_DIV_CERO_EN : when defined, div/mod by zero finishes in one step.
//                     The result is 0, Z = 1 and the extra output divCero = 1.
//                     When undefined, the divider produces its natural result:
//                     quotient = all ones and remainder = A.
// -----------------------------------------------------------------------------
module alu_secuencial #(
   parameter int ancho = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inicio,
   input  logic [ancho:0]   operandoA,
   input  logic [ancho:0]   operandoB,
   input  logic [3:0]       seleccion,
   output logic             ocupado,
   output logic             listo,
   output logic [ancho:0]   resultado,
   output logic             N,
   output logic             Z,
   output logic             C,
   output logic             V
`ifdef ALU_DIV_CERO_EN
   ,
   output logic             divCero
`endif
);

   localparam int W  = ancho + 1;
   localparam int CW = (W > 1) ? $clog2(W) : 1;

   localparam logic [1:0] REPOSO  = 2'd0;
   localparam logic [1:0] CALCULO = 2'd1;
   localparam logic [1:0] FIN     = 2'd2;

   localparam logic [3:0] OP_SUMA  = 4'd0;
   localparam logic [3:0] OP_RESTA = 4'd1;
   localparam logic [3:0] OP_MULT  = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_MOD   = 4'd4;
   localparam logic [3:0] OP_AND   = 4'd5;
   localparam logic [3:0] OP_OR    = 4'd6;
   localparam logic [3:0] OP_XOR   = 4'd7;
   localparam logic [3:0] OP_SHL   = 4'd8;
   localparam logic [3:0] OP_SHR   = 4'd9;

   // State and latched request
   logic [1:0]    estado_q, estado_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [W-1:0]  a_q, a_d;
   logic [W-1:0]  b_q, b_d;
   logic [3:0]    op_q, op_d;

   // Shared iteration datapath.
   // For multiply, {acc, low} is the 2W-bit product register.
   // For divide, acc is the partial remainder and low shifts the dividend
   // out while the quotient bits shift in.
   logic [W-1:0]  acc_q, acc_d;
   logic [W-1:0]  low_q, low_d;

   // Registered outputs
   logic [W-1:0]  resultado_q, resultado_d;
   logic          n_q, n_d;
   logic          z_q, z_d;
   logic          c_q, c_d;
   logic          v_q, v_d;
   logic          listo_q, listo_d;
   logic          dz_q, dz_d;

   // Iteration step signals
   logic [W:0]    mult_sum;
   logic [2*W:0]  mult_ext;
   logic [W:0]    div_tmp;
   logic [W:0]    div_diff;
   logic          div_ge;
   logic [W:0]    div_qext;

   // Final-result signals
   logic [W:0]    suma_ext;
   logic [W:0]    resta_ext;
   logic [W-1:0]  res_calc;
   logic          c_calc;
   logic          v_calc;
   logic          dz_calc;

   logic          req_iterativa;

   // Only mul/div/mod go through the iterative state.
   // With the build option enabled, a zero divisor bypasses the divider.
   always_comb begin
      req_iterativa = (seleccion == OP_MULT) || (seleccion == OP_DIV) ||
                      (seleccion == OP_MOD);
`ifdef ALU_DIV_CERO_EN
      if (((seleccion == OP_DIV) || (seleccion == OP_MOD)) && (operandoB == '0)) begin
         req_iterativa = 1'b0;
      end
`endif
   end

   // One shift-add multiply step.
   // The carry out of the add goes into the top bit, and the whole
   // 2W-bit register shifts right by one.
   always_comb begin
      if (low_q[0]) begin
         mult_sum = {1'b0, acc_q} + {1'b0, b_q};
      end else begin
         mult_sum = {1'b0, acc_q};
      end
      mult_ext = {mult_sum, low_q};
   end

   // One restoring-division step.
   // Shift the next dividend bit into the remainder and subtract B if it fits.
   // The compare is done at W+1 bits so the shifted remainder cannot overflow.
   always_comb begin
      div_tmp  = {acc_q, low_q[W-1]};
      div_diff = div_tmp - {1'b0, b_q};
      div_ge   = (div_tmp >= {1'b0, b_q});
      div_qext = {low_q, div_ge};
   end

   assign suma_ext  = {1'b0, a_q} + {1'b0, b_q};
   assign resta_ext = {1'b0, a_q} - {1'b0, b_q};

   // Final result selection, evaluated in FIN from the latched request
   always_comb begin
      res_calc = '0;
      c_calc   = 1'b0;
      v_calc   = 1'b0;
      dz_calc  = 1'b0;
      case (op_q)
         OP_SUMA: begin
            res_calc = suma_ext[W-1:0];
            c_calc   = suma_ext[W];
         end
         OP_RESTA: begin
            // The top bit of the extended difference is the borrow (A < B)
            res_calc = resta_ext[W-1:0];
            c_calc   = resta_ext[W];
         end
         OP_MULT: begin
            res_calc = low_q;
            v_calc   = |acc_q;
         end
         OP_DIV: begin
`ifdef ALU_DIV_CERO_EN
            if (b_q == '0) begin
               dz_calc = 1'b1;
            end else begin
               res_calc = low_q;
            end
`else
            res_calc = low_q;
`endif
         end
         OP_MOD: begin
`ifdef ALU_DIV_CERO_EN
            if (b_q == '0) begin
               dz_calc = 1'b1;
            end else begin
               res_calc = acc_q;
            end
`else
            res_calc = acc_q;
`endif
         end
         OP_AND: res_calc = a_q & b_q;
         OP_OR:  res_calc = a_q | b_q;
         OP_XOR: res_calc = a_q ^ b_q;
         // A logical shift by W or more already yields all zeros
         OP_SHL: res_calc = a_q << b_q;
         OP_SHR: res_calc = a_q >> b_q;
         default: res_calc = '0;
      endcase
   end

   // Next-state logic
   always_comb begin
      estado_d    = estado_q;
      cnt_d       = cnt_q;
      a_d         = a_q;
      b_d         = b_q;
      op_d        = op_q;
      acc_d       = acc_q;
      low_d       = low_q;
      resultado_d = resultado_q;
      n_d         = n_q;
      z_d         = z_q;
      c_d         = c_q;
      v_d         = v_q;
      dz_d        = dz_q;
      listo_d     = 1'b0;

      case (estado_q)
         REPOSO: begin
            if (inicio) begin
               a_d   = operandoA;
               b_d   = operandoB;
               op_d  = seleccion;
               cnt_d = CW'(W - 1);
               acc_d = '0;
               // A is the multiplier for mul and the dividend for div/mod
               low_d = operandoA;
               estado_d = req_iterativa ? CALCULO : FIN;
            end
         end
         CALCULO: begin
            if (op_q == OP_MULT) begin
               acc_d = mult_ext[2*W:W+1];
               low_d = mult_ext[W:1];
            end else begin
               acc_d = div_ge ? div_diff[W-1:0] : div_tmp[W-1:0];
               low_d = div_qext[W-1:0];
            end
            if (cnt_q == '0) begin
               estado_d = FIN;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         FIN: begin
            resultado_d = res_calc;
            n_d         = res_calc[W-1];
            z_d         = (res_calc == '0);
            c_d         = c_calc;
            v_d         = v_calc;
            dz_d        = dz_calc;
            listo_d     = 1'b1;
            estado_d    = REPOSO;
         end
         default: begin
            estado_d = REPOSO;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         estado_q    <= REPOSO;
         cnt_q       <= '0;
         a_q         <= '0;
         b_q         <= '0;
         op_q        <= '0;
         acc_q       <= '0;
         low_q       <= '0;
         resultado_q <= '0;
         n_q         <= 1'b0;
         z_q         <= 1'b0;
         c_q         <= 1'b0;
         v_q         <= 1'b0;
         dz_q        <= 1'b0;
         listo_q     <= 1'b0;
      end else begin
         estado_q    <= estado_d;
         cnt_q       <= cnt_d;
         a_q         <= a_d;
         b_q         <= b_d;
         op_q        <= op_d;
         acc_q       <= acc_d;
         low_q       <= low_d;
         resultado_q <= resultado_d;
         n_q         <= n_d;
         z_q         <= z_d;
         c_q         <= c_d;
         v_q         <= v_d;
         dz_q        <= dz_d;
         listo_q     <= listo_d;
      end
   end

   assign ocupado   = (estado_q != REPOSO);
   assign listo     = listo_q;
   assign resultado = resultado_q;
   assign N         = n_q;
   assign Z         = z_q;
   assign C         = c_q;
   assign V         = v_q;
`ifdef ALU_DIV_CERO_EN
   assign divCero   = dz_q;
`else
   // Without the build option, the zero-divisor flag has no output port
   logic dz_unused;
   assign dz_unused = dz_q;
`endif

endmodule

// File: tb/tb_alu_secuencial.sv
// -----------------------------------------------------------------------------
// tb_alu_secuencial
//
// Self-checking bench for alu_secuencial with ancho = 3 (W = 4).
// It runs:
//   - a table of directed vectors with fixed expected values;
//   - hand-written sequences for the multi-cycle corner cases:
//     an ignored request, a mid-operation reset and back-to-back requests;
//   - randomized requests checked against an arithmetic reference model.
// With ALU_DIV_CERO_EN defined, it also connects and checks divCero.
// -----------------------------------------------------------------------------
module tb_alu_secuencial;

   localparam int ANCHO = 3;
   localparam int W     = ANCHO + 1;

   logic          clk = 1'b0;
   logic          reset;
   logic          inicio;
   logic [W-1:0]  op_a;
   logic [W-1:0]  op_b;
   logic [3:0]    sel;
   logic          ocupado;
   logic          listo;
   logic [W-1:0]  resultado;
   logic          n_o, z_o, c_o, v_o;
`ifdef ALU_DIV_CERO_EN
   logic          dz_o;
`endif

   int vectors     = 0;
   int miscompares = 0;

   typedef struct {
      logic [3:0]   sel;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] res;
      logic         n;
      logic         z;
      logic         c;
      logic         v;
      logic         dz;
      int           lat;
   } vec_t;

   vec_t tbl[15];

   alu_secuencial #(.ancho(ANCHO)) dut (
      .clk       (clk),
      .reset     (reset),
      .inicio    (inicio),
      .operandoA (op_a),
      .operandoB (op_b),
      .seleccion (sel),
      .ocupado   (ocupado),
      .listo     (listo),
      .resultado (resultado),
      .N         (n_o),
      .Z         (z_o),
      .C         (c_o),
      .V         (v_o)
`ifdef ALU_DIV_CERO_EN
      ,
      .divCero   (dz_o)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   function automatic vec_t mk(input int s, input int a, input int b, input int r,
                               input int n, input int z, input int c, input int v,
                               input int dz, input int lat);
      vec_t e;
      e.sel = 4'(s);
      e.a   = W'(a);
      e.b   = W'(b);
      e.res = W'(r);
      e.n   = 1'(n);
      e.z   = 1'(z);
      e.c   = 1'(c);
      e.v   = 1'(v);
      e.dz  = 1'(dz);
      e.lat = lat;
      return e;
   endfunction

   // Reference model: plain integer arithmetic, truncated to W bits
   function automatic vec_t model(input logic [3:0] s, input logic [W-1:0] a,
                                  input logic [W-1:0] b);
      vec_t   e;
      longint ua = longint'(a);
      longint ub = longint'(b);
      longint m  = longint'(1) << W;
      longint r  = 0;
      e.sel = s; e.a = a; e.b = b;
      e.c = 1'b0; e.v = 1'b0; e.dz = 1'b0; e.lat = 1;
      case (s)
         4'd0: begin r = ua + ub; e.c = (r >= m); end
         4'd1: begin e.c = (ua < ub); r = ua - ub + m; end
         4'd2: begin r = ua * ub; e.v = (r >= m); e.lat = W + 1; end
         4'd3, 4'd4: begin
            if (ub == 0) begin
`ifdef ALU_DIV_CERO_EN
               r = 0; e.dz = 1'b1;
`else
               r = (s == 4'd3) ? m - 1 : ua;
               e.lat = W + 1;
`endif
            end else begin
               r = (s == 4'd3) ? ua / ub : ua % ub;
               e.lat = W + 1;
            end
         end
         4'd5: r = longint'(a & b);
         4'd6: r = longint'(a | b);
         4'd7: r = longint'(a ^ b);
         4'd8: r = (ub >= W) ? 0 : (ua << ub);
         4'd9: r = (ub >= W) ? 0 : (ua >> ub);
         default: r = 0;
      endcase
      r = r % m;
      e.res = W'(r);
      e.n = (r >= m / 2);
      e.z = (r == 0);
      return e;
   endfunction

   // Issue one request and wait for listo.
   // lat is the number of clock edges from acceptance to listo.
   task automatic do_op(input logic [3:0] s, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat, output logic ocup0);
      @(negedge clk);
      inicio = 1'b1; sel = s; op_a = a; op_b = b;
      @(posedge clk);
      @(negedge clk);
      inicio = 1'b0;
      ocup0  = ocupado;
      lat    = 0;
      while (listo !== 1'b1 && lat < 40) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
   endtask

   task automatic check_op(input string nm, input vec_t e);
      int   lat;
      logic ocup0;
      do_op(e.sel, e.a, e.b, lat, ocup0);
      $display("op %s sel=%0d a=%0h b=%0h -> res=%0h NZCV=%b%b%b%b lat=%0d",
               nm, e.sel, e.a, e.b, resultado, n_o, z_o, c_o, v_o, lat);
      chk({nm, ".lat"},    32'(lat), 32'(e.lat));
      chk({nm, ".res"},    32'(resultado), 32'(e.res));
      chk({nm, ".nzcv"},   32'({n_o, z_o, c_o, v_o}), 32'({e.n, e.z, e.c, e.v}));
      chk({nm, ".busy0"},  32'(ocup0), 32'd1);
      chk({nm, ".busyend"}, 32'(ocupado), 32'd0);
`ifdef ALU_DIV_CERO_EN
      chk({nm, ".divcero"}, 32'(dz_o), 32'(e.dz));
`endif
   endtask

   initial begin
      int   cnt;
      int   first;
      logic [W-1:0] cap_res;
      logic [3:0]   cap_flags;
      logic [3:0]   rs;
      logic [W-1:0] ra, rb;

      // Directed vectors (W = 4):  sel, a, b, res, N, Z, C, V, divCero, latency
      tbl[0]  = mk(0,  7,  9, 0,   0, 1, 1, 0, 0, 1);
      tbl[1]  = mk(2,  5,  6, 14,  1, 0, 0, 1, 0, 5);
      tbl[2]  = mk(3, 13,  4, 3,   0, 0, 0, 0, 0, 5);
      tbl[3]  = mk(4, 13,  4, 1,   0, 0, 0, 0, 0, 5);
`ifdef ALU_DIV_CERO_EN
      tbl[4]  = mk(3,  9,  0, 0,   0, 1, 0, 0, 1, 1);
      tbl[5]  = mk(4,  9,  0, 0,   0, 1, 0, 0, 1, 1);
`else
      tbl[4]  = mk(3,  9,  0, 15,  1, 0, 0, 0, 0, 5);
      tbl[5]  = mk(4,  9,  0, 9,   1, 0, 0, 0, 0, 5);
`endif
      tbl[6]  = mk(8,  3,  5, 0,   0, 1, 0, 0, 0, 1);
      tbl[7]  = mk(9, 12,  2, 3,   0, 0, 0, 0, 0, 1);
      tbl[8]  = mk(12, 5,  7, 0,   0, 1, 0, 0, 0, 1);
      tbl[9]  = mk(1,  3,  5, 14,  1, 0, 1, 0, 0, 1);
      tbl[10] = mk(1,  5,  5, 0,   0, 1, 0, 0, 0, 1);
      tbl[11] = mk(5, 12, 10, 8,   1, 0, 0, 0, 0, 1);
      tbl[12] = mk(6,  5,  2, 7,   0, 0, 0, 0, 0, 1);
      tbl[13] = mk(7, 15,  5, 10,  1, 0, 0, 0, 0, 1);
      tbl[14] = mk(2, 15, 15, 1,   0, 0, 0, 1, 0, 5);

      reset = 1'b1; inicio = 1'b0; sel = '0; op_a = '0; op_b = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset.res",   32'(resultado), 32'd0);
      chk("reset.flags", 32'({n_o, z_o, c_o, v_o, listo, ocupado}), 32'd0);
      reset = 1'b0;

      for (int i = 0; i < 15; i++) begin
         check_op($sformatf("tbl%0d", i), tbl[i]);
      end

      // A request while busy must be ignored: one listo, carrying the mult result
      @(negedge clk);
      inicio = 1'b1; sel = 4'd2; op_a = 4'd5; op_b = 4'd6;
      @(posedge clk);
      @(negedge clk);
      inicio = 1'b0;
      cnt = 0; first = 0; cap_res = '0; cap_flags = '0;
      for (int k = 1; k <= 10; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (k == 1) begin
            inicio = 1'b1; sel = 4'd0; op_a = 4'd1; op_b = 4'd1;
         end
         if (k == 2) inicio = 1'b0;
         if (listo === 1'b1) begin
            cnt++;
            if (first == 0) begin
               first = k; cap_res = resultado; cap_flags = {n_o, z_o, c_o, v_o};
            end
         end
      end
      $display("op ignore_busy: listo count=%0d at=%0d res=%0h", cnt, first, cap_res);
      chk("ignore.count", 32'(cnt), 32'd1);
      chk("ignore.lat",   32'(first), 32'd5);
      chk("ignore.res",   32'(cap_res), 32'hE);
      chk("ignore.nzcv",  32'(cap_flags), 32'b1001);

      // Leave nonzero outputs behind, then reset in the middle of a division
      check_op("pre_reset", model(4'd1, 4'd3, 4'd5));
      @(negedge clk);
      inicio = 1'b1; sel = 4'd3; op_a = 4'd15; op_b = 4'd2;
      @(posedge clk);
      @(negedge clk);
      inicio = 1'b0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      $display("op midreset: res=%0h NZCV=%b%b%b%b busy=%b listo=%b",
               resultado, n_o, z_o, c_o, v_o, ocupado, listo);
      chk("midreset.res",   32'(resultado), 32'd0);
      chk("midreset.flags", 32'({n_o, z_o, c_o, v_o, listo, ocupado}), 32'd0);
      cnt = 0;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (listo === 1'b1) cnt++;
      end
      chk("midreset.nolisto", 32'(cnt), 32'd0);
      check_op("post_reset", mk(0, 1, 1, 2, 0, 0, 0, 0, 0, 1));

      // Back-to-back: a new request arrives while listo is high
      check_op("b2b_first", model(4'd0, 4'd2, 4'd3));
      inicio = 1'b1; sel = 4'd1; op_a = 4'd7; op_b = 4'd1;
      @(posedge clk);
      @(negedge clk);
      inicio = 1'b0;
      chk("b2b.busy",  32'({listo, ocupado}), 32'b01);
      @(posedge clk);
      @(negedge clk);
      $display("op b2b_second: res=%0h listo=%b", resultado, listo);
      chk("b2b.listo", 32'(listo), 32'd1);
      chk("b2b.res",   32'(resultado), 32'd6);

      // Random requests against the reference model
      for (int i = 0; i < 150; i++) begin
         rs = 4'($urandom_range(0, 15));
         ra = W'($urandom);
         rb = ($urandom_range(0, 4) == 0) ? '0 : W'($urandom);
         check_op($sformatf("rnd%0d", i), model(rs, ra, rb));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/alu_secuencial.md
Name: alu_secuencial

Overview:
Multicycle successor of the lab ALU, with the same operation set and N/Z/C/V flag semantics. Adds a start/done handshake and registered outputs. Multiplication, division and modulo run iteratively over `W` cycles instead of as wide combinational arrays, so the block closes timing at larger widths. It sits between the register file and the writeback/display stage of the lab datapath.

Parameters:
- ancho, default 3: MSB index of the operands. Data width `W = ancho+1`.

Ports:
- clk, input, 1: rising-edge clock.
- reset, input, 1: synchronous, active-high reset.
- inicio, input, 1: request strobe. Accepted only while `ocupado=0`.
- operandoA, input, `W`: operand A. Unsigned for mul/div/mod.
- operandoB, input, `W`: operand B. Also the shift amount for shift operations.
- seleccion, input, 4: opcode.
  - 0 suma, 1 resta, 2 mult, 3 div, 4 mod
  - 5 AND, 6 OR, 7 XOR, 8 shift left, 9 shift right (logical)
- ocupado, output, 1: high from the cycle after acceptance until `listo`.
- listo, output, 1: one-cycle pulse. `resultado` and the flags are valid from this cycle.
- resultado, output, `W`: registered result. Holds its value until the next `listo`.
- N, Z, C, V, output, 1 each: registered flags, updated only together with `resultado`.

Behaviour:
- Reset: synchronous and active-high. Clears state to `REPOSO` and drives `ocupado`, `listo`, `resultado`, N, Z, C and V to 0.
- Reset mid-operation aborts the operation. No `listo` is produced and no partial result is kept.
- States:
  - `REPOSO`:
    - On `inicio=1`, latch `operandoA`, `operandoB` and `seleccion`.
    - Opcodes 0-1 and 5-15 go to `FIN`.
    - Opcodes 2-4 go to `CALCULO` with the iteration counter set to `W-1`.
    - `inicio=0` stays in `REPOSO`.
  - `CALCULO`:
    - One iteration per cycle.
    - mult: shift-add over a `2W`-bit product register.
    - div/mod: restoring division with a `W`-bit partial remainder.
    - Goes to `FIN` when the counter reaches 0.
  - `FIN`: register the result and flags, pulse `listo` for 1 cycle, return to `REPOSO`.
- Latency, with request accepted at edge t:
  - Single-step ops: `listo` at t+1.
  - mult/div/mod: `listo` at t+W+1.
- Back-to-back requests: `inicio` may be asserted in the same cycle `listo` is high. It is accepted, giving a minimum interval of 2 cycles for single-step ops.
- `inicio` while `ocupado=1` is ignored. The operation in flight is not disturbed.
- `ocupado` is low in `REPOSO` and high in `CALCULO` and `FIN`.
- Arithmetic: all results are truncated to `W` bits.
  - suma: C = carry out of bit ancho.
  - resta: computes A-B. C = borrow (1 when A<B).
  - mult: V = 1 if product bits [2W-1:W] are nonzero.
  - C is 0 for every op other than suma/resta. V is 0 for every op other than mult.
- N = `resultado[ancho]`. Z = (`resultado == 0`). Both are evaluated for every opcode.
- Shifts:
  - Amount = `operandoB`.
  - An amount of `W` or more yields 0.
  - Vacated bits are filled with 0.
- Division by zero (macro off): quotient = all ones, remainder = `operandoA`. This is the natural restoring-divider outcome.
- Opcodes 10-15: `resultado=0`, Z=1, N=C=V=0, `listo` at t+1.

Optional Feature:
- Macro: `ALU_DIV_CERO_EN`.
- Defined:
  - Adds output port `divCero` (1 bit), reset to 0 and registered with the flags.
  - For div/mod with B=0, the block skips `CALCULO` and goes straight to `FIN`.
  - Result: `resultado=0`, Z=1, `divCero=1`, `listo` at t+1.
  - `divCero` is 0 for every other completion.
- Undefined: no `divCero` port. Division by zero follows the natural-outcome rule above.

Test Plan (ancho=3, W=4):
- Suma 7+9 (sel 0) accepted at t → `listo` at t+1; `resultado=0`, C=1, Z=1, N=0, V=0.
- Mult 5*6 (sel 2) → `ocupado` high t+1..t+5, `listo` at t+5; `resultado=0xE`, V=1, N=1, C=0.
- Div 13/4 (sel 3) → `resultado=3`, `listo` at t+5. Mod 13/4 (sel 4) → `resultado=1`. Div 9/0 → `resultado=0xF`, N=1 with macro off; with `ALU_DIV_CERO_EN`, `resultado=0`, Z=1, `divCero=1`, `listo` at t+1.
- `inicio` pulsed with sel 0 at t+2 during a mult accepted at t → ignored; only one `listo` at t+5, carrying the mult result.
- `reset` at t+3 during div 15/2 → next cycle all outputs 0, state `REPOSO`, no `listo`. A new suma 1+1 then returns 2 at acceptance+1.
- Shift left 0x3 by 5 (sel 8) → `resultado=0`, Z=1. Shift right 0xC by 2 (sel 9) → 0x3. Sel 12 → `resultado=0`, Z=1, `listo` at t+1.
